// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared ALU: IDLE -> EXEC -> RESP.
// Round-robin by default; define ALU_ARB_FIXED_PRIO_EN for fixed priority.
module alu_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             r0_valid,
  input  logic             r1_valid,
  output logic             r0_ready,
  output logic             r1_ready,
  input  logic [WIDTH-1:0] r0_a,
  input  logic [WIDTH-1:0] r0_b,
  input  logic [WIDTH-1:0] r1_a,
  input  logic [WIDTH-1:0] r1_b,
  input  logic [2:0]       r0_ctrl,
  input  logic [2:0]       r1_ctrl,
  input  logic             r0_flag,
  input  logic             r1_flag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_ctrl,
  output logic             alu_f,
  input  logic [WIDTH-1:0] alu_c,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_accept;
  logic             w_pick;
  logic             r_rsp_id;
  logic [WIDTH-1:0] r_rsp_data;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [2:0]       r_alu_ctrl;
  logic             r_alu_f;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign w_pick = ~r0_valid;
`else
  logic r_last_grant;
  logic w_both;

  // On a tie the requester that did not win the last tie goes first.
  assign w_both = r0_valid & r1_valid;
  assign w_pick = w_both ? ~r_last_grant : r1_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= 1'b1;
    end else if (w_accept && w_both) begin
      r_last_grant <= w_pick;
    end
  end
`endif

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!rst && (r0_valid || r1_valid)) begin
          w_accept = 1'b1;
          w_next   = EXEC;
        end
      end
      EXEC: w_next = RESP;
      RESP: begin
        if (rsp_ready) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  assign r0_ready = w_accept & ~w_pick;
  assign r1_ready = w_accept & w_pick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_rsp_id   <= 1'b0;
      r_rsp_data <= '0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_ctrl <= 3'd0;
      r_alu_f    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_rsp_id   <= w_pick;
        r_alu_a    <= w_pick ? r1_a    : r0_a;
        r_alu_b    <= w_pick ? r1_b    : r0_b;
        r_alu_ctrl <= w_pick ? r1_ctrl : r0_ctrl;
        r_alu_f    <= w_pick ? r1_flag : r0_flag;
      end
      if (r_state == EXEC) begin
        r_rsp_data <= alu_c;
      end
    end
  end

  assign rsp_valid = (r_state == RESP);
  assign busy      = (r_state != IDLE);
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_ctrl  = r_alu_ctrl;
  assign alu_f     = r_alu_f;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand and result width in bits.
REQ-002 SHALL have port clk, input, 1: single rising-edge clock.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have ports r0_valid / r1_valid, input, 1: requester 0/1 presents an operation.
REQ-005 SHALL have ports r0_ready / r1_ready, output, 1: requester 0/1 operation accepted this cycle.
REQ-006 SHALL have ports r0_a, r0_b / r1_a, r1_b, input, WIDTH: operands.
REQ-007 SHALL have ports r0_ctrl / r1_ctrl, input, 3: ALU control code.
REQ-008 SHALL have ports r0_flag / r1_flag, input, 1: ALU flag (operation variant select).
REQ-009 SHALL have port rsp_valid, output, 1: result available.
REQ-010 SHALL have port rsp_ready, input, 1: consumer takes the result.
REQ-011 SHALL have port rsp_id, output, 1: requester index owning the result.
REQ-012 SHALL have port rsp_data, output, WIDTH: ALU result.
REQ-013 SHALL have ports alu_a, alu_b (output, WIDTH), alu_ctrl (output, 3) and alu_f (output, 1): registered drive to the shared ALU.
REQ-014 SHALL have port alu_c, input, WIDTH: combinational ALU result.
REQ-015 SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-016 SHALL implement an FSM with states IDLE, EXEC and RESP.
REQ-017 In IDLE with at least one valid: SHALL grant one requester, assert only its ready combinationally in that cycle, latch its a, b, ctrl, flag into alu_* and its index into rsp_id, then go to EXEC.
REQ-018 In IDLE with no valid: SHALL hold both readies low and stay in IDLE.
REQ-019 Readies SHALL be low in EXEC and RESP; a valid held high during those states SHALL wait and not be dropped.
REQ-020 In EXEC: SHALL register alu_c into rsp_data at the end of the cycle, then go to RESP.
REQ-021 In RESP: SHALL hold rsp_valid=1 and keep rsp_data/rsp_id stable until rsp_ready=1, then go to IDLE.
REQ-022 Latency: SHALL assert rsp_valid exactly 2 cycles after the accept edge; maximum throughput is one operation per 3 cycles.
REQ-023 Arbitration (default): SHALL be round-robin using a last_grant register; when both are valid, the requester not in last_grant wins.
REQ-024 SHALL update last_grant only at accept and only when both requesters were valid; a single requester SHALL win without changing priority.
REQ-025 SHALL hold alu_* outputs stable from accept until the next accept.
REQ-026 SHALL pass results through unmodified; no width extension and no carry out.

Reset
REQ-027 On rst=1: SHALL go to IDLE immediately, including mid-EXEC or mid-RESP.
REQ-028 On rst=1: SHALL drive rsp_valid=0, rsp_id=0, rsp_data=0, alu_a=alu_b=0, alu_ctrl=0, alu_f=0, busy=0, both readies=0 and last_grant=1.
REQ-029 An in-flight result SHALL be discarded on reset, and no rsp_valid pulse SHALL follow reset release.

Configuration
REQ-030 With ALU_ARB_FIXED_PRIO_EN defined: SHALL use fixed priority, requester 0 always winning ties, and SHALL remove the last_grant register.
REQ-031 Without ALU_ARB_FIXED_PRIO_EN: SHALL use the round-robin arbitration of REQ-023/024.

Verification
REQ-032 r0 only, a=0x0F, b=0x05, ctrl=011, flag=1, rsp_ready=1 -> r0_ready high in the accept cycle, rsp_valid 2 cycles later, rsp_data=0x14, rsp_id=0.
REQ-033 r1 only, a=0x0F, b=0x05, ctrl=011, flag=0 -> rsp_data=0x0A, rsp_id=1.
REQ-034 Both valid continuously after reset, rsp_ready=1 -> grant order 0,1,0,1; with ALU_ARB_FIXED_PRIO_EN -> order 0,0,0.
REQ-035 Result 0xFA (a=0x0F, b=0x05, ctrl=000, flag=1) with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_data=0xFA held; r0_ready and r1_ready stay low.
REQ-036 rst pulsed while in EXEC -> next cycle IDLE, rsp_valid=0, busy=0, all alu_*=0; next grant goes to r0.
